// File: rtl/fifo_in_sample_writer.sv
// Captures a frame of ADC samples, packs two per 32-bit word and pushes them to an Avalon-MM FIFO input.
// Optional FIFO_IN_WRITER_HDR_EN prepends a {16'hA55A, frame_count} header word to every frame.
module fifo_in_sample_writer #(
   parameter int SAMPLE_W    = 12,
   parameter int NUM_SAMPLES = 1024,
   parameter int BUF_DEPTH   = 4
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic                start,
   input  logic [SAMPLE_W-1:0] adc_data,
   input  logic                adc_valid,
   output logic [31:0]         fifo_in_writedata,
   output logic                fifo_in_write,
   input  logic                fifo_in_waitrequest,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic [15:0]         frame_count
);

   localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int OCC_W = $clog2(BUF_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      DRAIN
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic              w_startAccept;
   logic              w_sampleAccept;
   logic              w_frameDone;

   logic [CNT_W-1:0]  r_sampleCnt;
   logic [15:0]       r_lowLane;
   logic [15:0]       r_frameCount;
   logic              r_overflow;

   logic [31:0]       r_buf [BUF_DEPTH];
   logic [PTR_W-1:0]  r_wrPtr;
   logic [PTR_W-1:0]  r_rdPtr;
   logic [OCC_W-1:0]  r_count;
   logic [31:0]       r_lastData;

   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_enq;
   logic              w_push;
   logic              w_drop;
   logic [31:0]       w_enqData;
   logic              w_lastSample;

   assign w_empty      = (r_count == '0);
   assign w_full       = (r_count == OCC_W'(BUF_DEPTH));
   assign w_lastSample = (r_sampleCnt == CNT_W'(NUM_SAMPLES - 1));

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState    = r_state;
      w_startAccept  = 1'b0;
      w_sampleAccept = 1'b0;
      w_frameDone    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_startAccept = 1'b1;
               w_nextState   = CAPTURE;
            end
         end
         CAPTURE: begin
            if (adc_valid) begin
               w_sampleAccept = 1'b1;
               if (w_lastSample) begin
                  w_nextState = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (w_empty) begin
               w_frameDone = 1'b1;
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // A word is complete when the odd sample of a pair arrives; the header rides the start edge.
`ifdef FIFO_IN_WRITER_HDR_EN
   assign w_enq     = (w_sampleAccept & r_sampleCnt[0]) | w_startAccept;
   assign w_enqData = w_startAccept ? {16'hA55A, r_frameCount}
                                    : {16'(adc_data), r_lowLane};
`else
   assign w_enq     = w_sampleAccept & r_sampleCnt[0];
   assign w_enqData = {16'(adc_data), r_lowLane};
`endif

   assign w_pop  = fifo_in_write & ~fifo_in_waitrequest;
   assign w_push = w_enq & (~w_full | w_pop);
   assign w_drop = w_enq & w_full & ~w_pop;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_sampleCnt  <= '0;
         r_lowLane    <= '0;
         r_frameCount <= '0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_startAccept) begin
            r_sampleCnt <= '0;
         end else if (w_sampleAccept) begin
            r_sampleCnt <= r_sampleCnt + CNT_W'(1);
         end
         if (w_sampleAccept && !r_sampleCnt[0]) begin
            r_lowLane <= 16'(adc_data);
         end
         if (w_startAccept) begin
            r_overflow <= 1'b0;
         end else if (w_drop) begin
            r_overflow <= 1'b1;
         end
         if (w_frameDone) begin
            r_frameCount <= r_frameCount + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_count    <= '0;
         r_lastData <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr    <= r_rdPtr + PTR_W'(1);
            r_lastData <= r_buf[r_rdPtr];
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + OCC_W'(1);
            2'b01:   r_count <= r_count - OCC_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: a slot is only ever read after it has been written.
   always_ff @(posedge clk_clk) begin
      if (w_push) begin
         r_buf[r_wrPtr] <= w_enqData;
      end
   end

   assign fifo_in_write     = ~w_empty;
   assign fifo_in_writedata = w_empty ? r_lastData : r_buf[r_rdPtr];
   assign busy              = (r_state != IDLE);
   assign done              = w_frameDone;
   assign overflow          = r_overflow;
   assign frame_count       = r_frameCount;

endmodule

// File: tb/tb_fifo_in_sample_writer.sv
// Scoreboard bench for fifo_in_sample_writer: an 8-sample instance for most scenarios and a
// 16-sample instance for the overflow case. Header expectations follow FIFO_IN_WRITER_HDR_EN.
module tb_fifo_in_sample_writer;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic [11:0] adcData;
   logic        adcValid;

   logic        start8, waitreq8, write8, busy8, done8, ovf8;
   logic [31:0] wdata8;
   logic [15:0] frameCount8;

   logic        start16, waitreq16, write16, busy16, done16, ovf16;
   logic [31:0] wdata16;
   logic [15:0] frameCount16;

   int          checks;
   int          errors;
   int          cycle;
   int          lastXfer8;
   int          lastXfer16;

   logic [31:0] q8[$];
   logic [31:0] q16[$];
   int          mIdx[2];
   logic [15:0] mLow[2];
   bit          mCap[2];
   logic        expOvf[2];
   logic [15:0] expFrame[2];

   fifo_in_sample_writer #(.SAMPLE_W(12), .NUM_SAMPLES(8), .BUF_DEPTH(DEPTH)) dut8 (
      .clk_clk(clk), .reset_reset(reset), .start(start8),
      .adc_data(adcData), .adc_valid(adcValid),
      .fifo_in_writedata(wdata8), .fifo_in_write(write8), .fifo_in_waitrequest(waitreq8),
      .busy(busy8), .done(done8), .overflow(ovf8), .frame_count(frameCount8)
   );

   fifo_in_sample_writer #(.SAMPLE_W(12), .NUM_SAMPLES(16), .BUF_DEPTH(DEPTH)) dut16 (
      .clk_clk(clk), .reset_reset(reset), .start(start16),
      .adc_data(adcData), .adc_valid(adcValid),
      .fifo_in_writedata(wdata16), .fifo_in_write(write16), .fifo_in_waitrequest(waitreq16),
      .busy(busy16), .done(done16), .overflow(ovf16), .frame_count(frameCount16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Model of the word buffer: a word is lost when the buffer is full and nothing leaves this edge.
   task automatic pushWord(input int target, input logic [31:0] word);
      bit xfer;
      if (target == 0) begin
         xfer = (q8.size() > 0) && !waitreq8;
         if (q8.size() == DEPTH && !xfer) expOvf[0] = 1'b1;
         else q8.push_back(word);
      end else begin
         xfer = (q16.size() > 0) && !waitreq16;
         if (q16.size() == DEPTH && !xfer) expOvf[1] = 1'b1;
         else q16.push_back(word);
      end
   endtask

   task automatic applyStimulus(input int target, input logic valid, input logic [11:0] s);
      adcValid = valid;
      adcData  = s;
      if (valid && mCap[target]) begin
         if (mIdx[target] % 2 == 0) mLow[target] = {4'h0, s};
         else pushWord(target, {4'h0, s, mLow[target]});
         mIdx[target]++;
         if (mIdx[target] == (target == 0 ? 8 : 16)) mCap[target] = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   task automatic startFrame(input int target);
      adcValid = 1'b0;
      if (target == 0) start8 = 1'b1;
      else start16 = 1'b1;
      mCap[target]   = 1'b1;
      mIdx[target]   = 0;
      expOvf[target] = 1'b0;
`ifdef FIFO_IN_WRITER_HDR_EN
      pushWord(target, {16'hA55A, expFrame[target]});
`endif
      @(posedge clk); #1;
      start8  = 1'b0;
      start16 = 1'b0;
   endtask

   task automatic waitDone(input int target, input int budget);
      bit seen;
      seen = 1'b0;
      adcValid = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((target == 0) ? done8 : done16) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) checkOutput("doneTimeout", 32'((target == 0) ? done8 : done16), 32'd1);
      @(posedge clk); #1;
      expFrame[target]++;
      if (target == 0) begin
         checkOutput("frameCount8", 32'(frameCount8), 32'(expFrame[0]));
         checkOutput("overflow8", 32'(ovf8), 32'(expOvf[0]));
         checkOutput("busy8", 32'(busy8), 32'd0);
         checkOutput("wordsLeft8", 32'(q8.size()), 32'd0);
      end else begin
         checkOutput("frameCount16", 32'(frameCount16), 32'(expFrame[1]));
         checkOutput("overflow16", 32'(ovf16), 32'(expOvf[1]));
         checkOutput("busy16", 32'(busy16), 32'd0);
         checkOutput("wordsLeft16", 32'(q16.size()), 32'd0);
      end
   endtask

   // Transfers are observed on the falling edge ahead of the rising edge that completes them.
   always @(negedge clk) begin
      if (!reset) begin
         if (write8) begin
            if (q8.size() == 0) checkOutput("unexpectedWrite8", 32'(write8), 32'd0);
            else begin
               checkOutput("wdata8", wdata8, q8[0]);
               if (!waitreq8) begin
                  void'(q8.pop_front());
                  lastXfer8 = cycle;
               end
            end
         end
         if (done8) checkOutput("doneLatency8", 32'(cycle - lastXfer8), 32'd1);
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (write16) begin
            if (q16.size() == 0) checkOutput("unexpectedWrite16", 32'(write16), 32'd0);
            else begin
               checkOutput("wdata16", wdata16, q16[0]);
               if (!waitreq16) begin
                  void'(q16.pop_front());
                  lastXfer16 = cycle;
               end
            end
         end
         if (done16) checkOutput("doneLatency16", 32'(cycle - lastXfer16), 32'd1);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks = 0; errors = 0; cycle = 0; lastXfer8 = 0; lastXfer16 = 0;
      reset = 1'b1; adcData = '0; adcValid = 1'b0;
      start8 = 1'b0; waitreq8 = 1'b0; start16 = 1'b0; waitreq16 = 1'b0;
      for (int t = 0; t < 2; t++) begin
         mIdx[t] = 0; mLow[t] = '0; mCap[t] = 1'b0; expOvf[t] = 1'b0; expFrame[t] = '0;
      end

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checkOutput("rstWrite", 32'(write8), 32'd0);
      checkOutput("rstBusy", 32'(busy8), 32'd0);
      checkOutput("rstDone", 32'(done8), 32'd0);
      checkOutput("rstOverflow", 32'(ovf8), 32'd0);
      checkOutput("rstFrameCount", 32'(frameCount8), 32'd0);
      checkOutput("rstWrite16", 32'(write16), 32'd0);
      @(posedge clk); #1;

      $display("[TB] back-to-back frame");
      startFrame(0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, (i == 7) ? 12'hFFF : 12'(i + 1));
      waitDone(0, 30);

      $display("[TB] stalled writes");
      startFrame(0);
      for (int k = 0; k < 12; k++) begin
         waitreq8 = (k >= 2);
         if (k < 8) applyStimulus(0, 1'b1, 12'(12'h100 + k));
         else applyStimulus(0, 1'b0, 12'h000);
      end
      waitreq8 = 1'b0;
      waitDone(0, 30);

      $display("[TB] buffer overflow");
      waitreq16 = 1'b1;
      startFrame(1);
      for (int i = 0; i < 16; i++) applyStimulus(1, 1'b1, 12'(12'h300 + 3 * i));
      applyStimulus(1, 1'b0, 12'h000);
      applyStimulus(1, 1'b0, 12'h000);
      checkOutput("overflowHeld16", 32'(ovf16), 32'(expOvf[1]));
      checkOutput("busyStalled16", 32'(busy16), 32'd1);
      waitreq16 = 1'b0;
      waitDone(1, 30);

      $display("[TB] ignored start and idle samples");
      applyStimulus(0, 1'b1, 12'hABC);
      adcValid = 1'b0;
      startFrame(0);
      for (int i = 0; i < 8; i++) begin
         start8 = (i == 3);
         applyStimulus(0, 1'b1, 12'(12'h200 + 7 * i));
      end
      start8 = 1'b0;
      waitDone(0, 30);

      $display("[TB] reset mid-frame");
      waitreq8 = 1'b1;
      startFrame(0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 12'(12'h0A0 + i));
      adcValid = 1'b0;
      reset = 1'b1;
      #1;
      checkOutput("asyncWrite", 32'(write8), 32'd0);
      checkOutput("asyncBusy", 32'(busy8), 32'd0);
      checkOutput("asyncFrameCount", 32'(frameCount8), 32'd0);
      q8.delete();
      q16.delete();
      for (int t = 0; t < 2; t++) begin
         mCap[t] = 1'b0; expOvf[t] = 1'b0; expFrame[t] = '0;
      end
      waitreq8 = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      startFrame(0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 12'(12'h5F0 + i));
      waitDone(0, 30);

      $display("[TB] second back-to-back frame");
      startFrame(0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 1'b1, 12'(12'hE00 - 5 * i));
      waitDone(0, 30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
